// File: rtl/cga_rgbi_encoder.sv
// cga_rgbi_encoder: converts 18-bit VGA-style RGB pixels into 4-bit CGA IRGB codes.
// Stage 1 quantises each channel to a 2-bit level; stage 2 maps the levels onto
// the 16-entry CGA palette and tracks pixel position and per-frame mismatch count.
// Build option: define CGA_RGBI_NEAREST_EN to map non-palette pixels to the
// nearest IRGB code instead of black.
module cga_rgbi_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [5:0]  red,
  input  logic [6:0]  green,
  input  logic [5:0]  blue,
  input  logic        hsync,
  input  logic        vsync,
  output logic [3:0]  video,
  output logic        out_valid,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        exact,
  output logic [9:0]  col,
  output logic [8:0]  row,
  output logic        frame_pulse,
  output logic [15:0] err_count
);

  localparam logic [9:0]  COL_MAX = 10'd1023;
  localparam logic [8:0]  ROW_MAX = 9'd511;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [1:0] quant(input logic [5:0] v);
    if (v < 6'd11)      return 2'd0;
    else if (v < 6'd32) return 2'd1;
    else if (v < 6'd53) return 2'd2;
    else                return 2'd3;
  endfunction

  // stage 1
  logic       s1_valid_q, s1_valid_d;
  logic [1:0] lvl_r_q, lvl_r_d;
  logic [1:0] lvl_g_q, lvl_g_d;
  logic [1:0] lvl_b_q, lvl_b_d;
  logic       s1_hs_q, s1_hs_d;
  logic       s1_vs_q, s1_vs_d;

  // stage 2 and frame bookkeeping
  logic [3:0]  video_q, video_d;
  logic        exact_q, exact_d;
  logic        out_valid_q, out_valid_d;
  logic        hsync_out_q, hsync_out_d;
  logic        vsync_out_q, vsync_out_d;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic        line_pend_q, line_pend_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;
  logic [15:0] err_count_q, err_count_d;
  logic        frame_pulse_q, frame_pulse_d;

  logic [3:0]  map_code;
  logic        map_exact;
  logic [1:0]  odd_cnt;
  logic        hs_rise;
  logic        vs_rise;
  logic [15:0] mis_inc;

  // stage 1: sample and quantise the pixel only on a strobe; syncs every cycle
  always_comb begin
    s1_valid_d = in_valid;
    s1_hs_d    = hsync;
    s1_vs_d    = vsync;
    lvl_r_d    = lvl_r_q;
    lvl_g_d    = lvl_g_q;
    lvl_b_d    = lvl_b_q;
    if (in_valid) begin
      lvl_r_d = quant(red);
      lvl_g_d = quant(green[6:1]);
      lvl_b_d = quant(blue);
    end
  end

  // palette lookup: level bit 0 selects intensity family, bit 1 is the colour bit
  always_comb begin
    map_code  = 4'h0;
    map_exact = 1'b0;
    odd_cnt   = {1'b0, lvl_r_q[0]} + {1'b0, lvl_g_q[0]} + {1'b0, lvl_b_q[0]};
    if (lvl_r_q == 2'd2 && lvl_g_q == 2'd1 && lvl_b_q == 2'd0) begin
      map_code  = 4'h6;
      map_exact = 1'b1;
    end else if (!lvl_r_q[0] && !lvl_g_q[0] && !lvl_b_q[0] &&
                 !(lvl_r_q == 2'd2 && lvl_g_q == 2'd2 && lvl_b_q == 2'd0)) begin
      map_code  = {1'b0, lvl_r_q[1], lvl_g_q[1], lvl_b_q[1]};
      map_exact = 1'b1;
    end else if (lvl_r_q[0] && lvl_g_q[0] && lvl_b_q[0]) begin
      map_code  = {1'b1, lvl_r_q[1], lvl_g_q[1], lvl_b_q[1]};
      map_exact = 1'b1;
    end else begin
`ifdef CGA_RGBI_NEAREST_EN
      if (odd_cnt >= 2'd2)
        map_code = {1'b1, &lvl_r_q, &lvl_g_q, &lvl_b_q};
      else
        map_code = {1'b0, lvl_r_q[1], lvl_g_q[1], lvl_b_q[1]};
`else
      map_code = 4'h0;
`endif
    end
  end

  // stage 2 outputs plus position and mismatch tracking, aligned with video
  always_comb begin
    hs_rise       = s1_hs_q & ~hsync_out_q;
    vs_rise       = s1_vs_q & ~vsync_out_q;
    video_d       = video_q;
    exact_d       = exact_q;
    out_valid_d   = s1_valid_q;
    hsync_out_d   = s1_hs_q;
    vsync_out_d   = s1_vs_q;
    col_d         = col_q;
    row_d         = row_q;
    line_pend_d   = line_pend_q;
    mis_inc       = mis_cnt_q;
    mis_cnt_d     = mis_cnt_q;
    err_count_d   = err_count_q;
    frame_pulse_d = vs_rise;

    if (s1_valid_q) begin
      video_d     = map_code;
      exact_d     = map_exact;
      line_pend_d = 1'b0;
      if (line_pend_q || hs_rise)
        col_d = 10'd0;
      else if (col_q != COL_MAX)
        col_d = col_q + 10'd1;
      if (!map_exact && mis_cnt_q != CNT_MAX)
        mis_inc = mis_cnt_q + 16'd1;
    end else if (hs_rise) begin
      line_pend_d = 1'b1;
    end

    // a coinciding vsync edge wins over the hsync increment
    if (vs_rise)
      row_d = 9'd0;
    else if (hs_rise && row_q != ROW_MAX)
      row_d = row_q + 9'd1;

    mis_cnt_d = mis_inc;
    if (vs_rise) begin
      err_count_d = mis_inc;
      mis_cnt_d   = 16'd0;
    end
  end

  // all state, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      lvl_r_q       <= 2'd0;
      lvl_g_q       <= 2'd0;
      lvl_b_q       <= 2'd0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      video_q       <= 4'h0;
      exact_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      hsync_out_q   <= 1'b0;
      vsync_out_q   <= 1'b0;
      col_q         <= 10'd0;
      row_q         <= 9'd0;
      line_pend_q   <= 1'b0;
      mis_cnt_q     <= 16'd0;
      err_count_q   <= 16'd0;
      frame_pulse_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      lvl_r_q       <= lvl_r_d;
      lvl_g_q       <= lvl_g_d;
      lvl_b_q       <= lvl_b_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      video_q       <= video_d;
      exact_q       <= exact_d;
      out_valid_q   <= out_valid_d;
      hsync_out_q   <= hsync_out_d;
      vsync_out_q   <= vsync_out_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_pend_q   <= line_pend_d;
      mis_cnt_q     <= mis_cnt_d;
      err_count_q   <= err_count_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  assign video       = video_q;
  assign exact       = exact_q;
  assign out_valid   = out_valid_q;
  assign hsync_out   = hsync_out_q;
  assign vsync_out   = vsync_out_q;
  assign col         = col_q;
  assign row         = row_q;
  assign frame_pulse = frame_pulse_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_cga_rgbi_encoder.sv
// Bench for cga_rgbi_encoder: directed scenarios plus randomized traffic, every
// cycle compared with a behavioural model built from the palette table.
module tb_cga_rgbi_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [5:0]  red;
  logic [6:0]  green;
  logic [5:0]  blue;
  logic        hsync;
  logic        vsync;
  logic [3:0]  video;
  logic        out_valid;
  logic        hsync_out;
  logic        vsync_out;
  logic        exact;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        frame_pulse;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  cga_rgbi_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync),
    .video(video), .out_valid(out_valid), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .exact(exact), .col(col), .row(row),
    .frame_pulse(frame_pulse), .err_count(err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int r, g, b;
    bit hs, vs;
  } rec_t;

  rec_t pipe_q[$];
  int pal_r[16], pal_g[16], pal_b[16];
  int m_video, m_exact, m_valid, m_hso, m_vso, m_col, m_row, m_pend;
  int m_cnt, m_err, m_fp;

  function automatic int qlev(input int v);
    if (v < 11) return 0;
    if (v < 32) return 1;
    if (v < 53) return 2;
    return 3;
  endfunction

  function automatic int lv2val(input int l);
    return l * 21;
  endfunction

  function automatic rec_t empty_rec();
    rec_t e;
    e.v = 0; e.r = 0; e.g = 0; e.b = 0; e.hs = 0; e.vs = 0;
    return e;
  endfunction

  task automatic build_palette();
    for (int c = 0; c < 16; c++) begin
      int i;
      i = (c >= 8) ? 1 : 0;
      pal_r[c] = i ? (((c / 4) % 2) ? 3 : 1) : (((c / 4) % 2) ? 2 : 0);
      pal_g[c] = i ? (((c / 2) % 2) ? 3 : 1) : (((c / 2) % 2) ? 2 : 0);
      pal_b[c] = i ? ((c % 2) ? 3 : 1) : ((c % 2) ? 2 : 0);
    end
    pal_r[6] = 2; pal_g[6] = 1; pal_b[6] = 0;
  endtask

  task automatic model_reset();
    m_video = 0; m_exact = 0; m_valid = 0; m_hso = 0; m_vso = 0;
    m_col = 0; m_row = 0; m_pend = 0; m_cnt = 0; m_err = 0; m_fp = 0;
    pipe_q.delete();
    pipe_q.push_back(empty_rec());
  endtask

  task automatic model_edge();
    rec_t cur, rec;
    int lr, lg, lb, code, ex, odd;
    bit hsr, vsr;
    if (!reset_n) begin
      model_reset();
      return;
    end
    cur.v = in_valid; cur.r = red; cur.g = green / 2; cur.b = blue;
    cur.hs = hsync; cur.vs = vsync;
    rec = pipe_q.pop_front();
    pipe_q.push_back(cur);
    hsr = rec.hs && (m_hso == 0);
    vsr = rec.vs && (m_vso == 0);
    if (rec.v) begin
      lr = qlev(rec.r); lg = qlev(rec.g); lb = qlev(rec.b);
      ex = 0; code = 0;
      for (int c = 0; c < 16; c++)
        if (pal_r[c] == lr && pal_g[c] == lg && pal_b[c] == lb) begin
          ex = 1; code = c;
        end
      if (ex == 0) begin
`ifdef CGA_RGBI_NEAREST_EN
        odd = (lr % 2) + (lg % 2) + (lb % 2);
        if (odd >= 2)
          code = 8 + ((lr == 3) ? 4 : 0) + ((lg == 3) ? 2 : 0) + ((lb == 3) ? 1 : 0);
        else
          code = ((lr >= 2) ? 4 : 0) + ((lg >= 2) ? 2 : 0) + ((lb >= 2) ? 1 : 0);
`else
        odd = 0;
        code = odd;
`endif
        if (m_cnt < 65535) m_cnt++;
      end
      m_video = code; m_exact = ex;
      m_col = (m_pend != 0 || hsr) ? 0 : ((m_col < 1023) ? m_col + 1 : 1023);
      m_pend = 0;
    end else if (hsr) begin
      m_pend = 1;
    end
    if (vsr) m_row = 0;
    else if (hsr && m_row < 511) m_row++;
    m_fp = vsr ? 1 : 0;
    if (vsr) begin
      m_err = m_cnt;
      m_cnt = 0;
    end
    m_valid = rec.v; m_hso = rec.hs; m_vso = rec.vs;
  endtask

  task automatic check_outputs();
    check("video", video, m_video);
    check("exact", exact, m_exact);
    check("out_valid", out_valid, m_valid);
    check("hsync_out", hsync_out, m_hso);
    check("vsync_out", vsync_out, m_vso);
    check("col", col, m_col);
    check("row", row, m_row);
    check("frame_pulse", frame_pulse, m_fp);
    check("err_count", err_count, m_err);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input int r, input int g, input int b,
                      input bit hs, input bit vs);
    in_valid = v;
    red   = r[5:0];
    green = g[6:0];
    blue  = b[5:0];
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pal_pix(input int c);
    step(1, lv2val(pal_r[c]), lv2val(pal_g[c]) * 2, lv2val(pal_b[c]), 0, 0);
  endtask

  task automatic hs_pulse();
    step(0, 0, 0, 0, 1, 0);
    idle();
  endtask

  task automatic vsync_frame(input int exp_err);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("frame_pulse_on", frame_pulse, 1);
    check("frame_err", err_count, exp_err);
    check("frame_row0", row, 0);
    idle();
    check("frame_pulse_off", frame_pulse, 0);
  endtask

  int exp_a, exp_b;
  bit r_hs, r_vs;

  initial begin
    build_palette();
    model_reset();
    reset_n = 0; in_valid = 0; red = 0; green = 0; blue = 0; hsync = 0; vsync = 0;
    idle();
    idle();
    check("rst_video", video, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err_count, 0);
    reset_n = 1;
    idle();

    // all 16 palette colours in order, 2-stage latency
    for (int i = 0; i < 16; i++) begin
      pal_pix(i);
      if (i == 0) check("lat_not_yet", out_valid, 0);
      else begin
        check("pal_video", video, i - 1);
        check("pal_exact", exact, 1);
      end
    end
    idle();
    check("pal_video_last", video, 15);
    idle();
    check("pal_held", video, 15);
    vsync_frame(0);

    // near-miss pixels
`ifdef CGA_RGBI_NEAREST_EN
    exp_a = 6; exp_b = 14;
`else
    exp_a = 0; exp_b = 0;
`endif
    step(1, 42, 84, 0, 0, 0);
    step(1, 63, 127, 40, 0, 0);
    check("near1_video", video, exp_a);
    check("near1_exact", exact, 0);
    idle();
    check("near2_video", video, exp_b);
    check("near2_exact", exact, 0);

    // one line of 640 pixels, then rows
    hs_pulse();
    for (int k = 0; k < 640; k++) begin
      pal_pix(k % 16);
      if (k >= 1) check("line_col", col, k - 1);
    end
    idle();
    check("line_col_end", col, 639);
    hs_pulse();
    hs_pulse();
    check("row3", row, 3);
    vsync_frame(2);

    // gaps in in_valid
    hs_pulse();
    pal_pix(9);
    idle();
    check("gap_video_a", video, 9);
    check("gap_col_a", col, 0);
    idle();
    check("gap_hold_video", video, 9);
    check("gap_hold_col", col, 0);
    idle();
    pal_pix(12);
    check("gap_hold2_video", video, 9);
    idle();
    check("gap_video_b", video, 12);
    check("gap_col_b", col, 1);

    // row saturation
    for (int k = 0; k < 520; k++) hs_pulse();
    check("row_sat", row, 511);

    // counter saturation and col saturation within one frame
    vsync_frame(0);
    for (int k = 0; k < 70000; k++) step(1, 42, 84, 0, 0, 0);
    idle();
    check("col_sat", col, 1023);
    vsync_frame(65535);
    for (int k = 0; k < 5; k++) pal_pix(k);
    vsync_frame(0);

    // reset mid-line with a pixel presented
    hs_pulse();
    pal_pix(3);
    pal_pix(3);
    pal_pix(3);
    reset_n = 0;
    pal_pix(5);
    check("mrst_video", video, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_col", col, 0);
    check("mrst_row", row, 0);
    reset_n = 1;
    idle();
    check("mrst_no_stale1", out_valid, 0);
    idle();
    check("mrst_no_stale2", out_valid, 0);
    check("mrst_video_after", video, 0);

    // randomized traffic
    r_hs = 0; r_vs = 0;
    for (int k = 0; k < 5000; k++) begin
      reset_n = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 39) == 0) r_hs = ~r_hs;
      if ($urandom_range(0, 299) == 0) r_vs = ~r_vs;
      if ($urandom_range(0, 1) == 0) begin
        int c;
        c = $urandom_range(0, 15);
        step($urandom_range(0, 9) < 7, lv2val(pal_r[c]) + $urandom_range(0, 3) - 1 + (pal_r[c] == 0 ? 1 : 0),
             (lv2val(pal_g[c]) * 2) + $urandom_range(0, 1), lv2val(pal_b[c]), r_hs, r_vs);
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 63), $urandom_range(0, 127),
             $urandom_range(0, 63), r_hs, r_vs);
      end
    end
    reset_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_rgbi_encoder.md
CGA_RGBI_ENCODER -- requirements
Module: cga_rgbi_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  pixel strobe; red/green/blue sampled only when 1.
REQ-004 SHALL have ports: red  input  6, green  input  7, blue  input  6  RGB pixel (VGA-port format).
REQ-005 SHALL have ports: hsync  input  1, vsync  input  1  active-high syncs, sampled every cycle.
REQ-006 SHALL have port: video  output  4  IRGB code {I,R,G,B}.
REQ-007 SHALL have ports: out_valid, hsync_out, vsync_out  output  1 each  in_valid/hsync/vsync delayed to align with video.
REQ-008 SHALL have port: exact  output  1  current pixel matched a palette entry exactly.
REQ-009 SHALL have ports: col  output  10, row  output  9  position of the pixel on video.
REQ-010 SHALL have ports: frame_pulse  output  1, err_count  output  16  end-of-frame strobe and the frame's latched mismatch count.

Function
REQ-011 SHALL quantise each channel, using green[6:1] (green[0] ignored), to level 0..3: value <11 -> 0, 11..31 -> 1, 32..52 -> 2, >=53 -> 3.
REQ-012 SHALL use a 2-stage pipeline (stage 1 quantise, stage 2 map); video/exact/out_valid/hsync_out/vsync_out valid exactly 2 cycles after their inputs.
REQ-013 SHALL set exact=1 when the (R,G,B) levels match exactly one of these 16 entries: I=0 entries with channels in {0,2} (brown excepted), code bit = level==2; I=1 entries with channels in {1,3}, code bit = level==3; brown (2,1,0) -> 4'h6; (2,2,0) -> exact=0.
REQ-014 SHALL hold video and exact at their previous values when the stage-2 out_valid is 0.
REQ-015 SHALL clear col to 0 on the first out_valid after a hsync_out rising edge; otherwise increment col by 1 per out_valid, saturating at 1023.
REQ-016 SHALL clear row to 0 on a vsync_out rising edge; increment row on each hsync_out rising edge, saturating at 511.
REQ-017 SHALL increment an internal mismatch counter on each out_valid with exact=0, saturating at 16'hFFFF.
REQ-018 SHALL, on a vsync_out rising edge, copy the mismatch counter (including a same-cycle increment) to err_count, pulse frame_pulse for one cycle, and clear the counter.
REQ-019 SHALL, when the hsync_out and vsync_out rising edges coincide, clear row to 0 and not increment it.

Reset
REQ-020 SHALL, while reset_n=0 at a clock edge, force video=0, exact=0, out_valid=0, hsync_out=0, vsync_out=0, col=0, row=0, frame_pulse=0, err_count=0, clear the mismatch counter and both pipeline stages.
REQ-021 SHALL treat the first sync edges after reset release as real edges (sync history reset to 0); a reset mid-frame discards in-flight pixels.

Configuration
REQ-022 SHALL, with CGA_RGBI_NEAREST_EN defined, map a non-matching pixel to its nearest code: I=1 when two or more channels are at odd levels (1 or 3), else I=0; for I=0 each code bit = level>=2; for I=1 each code bit = level==3; exact stays 0.
REQ-023 SHALL, without CGA_RGBI_NEAREST_EN, output video=4'h0 for any non-matching pixel; exact=0 and counting are unchanged.

Verification
REQ-024 SHALL test: feed all 16 palette RGB values (e.g. 6'd42/7'd43/6'd0 brown) -> video = 0..F in order, exact=1, 2-cycle latency, err_count=0 at next vsync.
REQ-025 SHALL test: red=6'd42, green=7'd84, blue=6'd0, then red=6'd63, green=7'd127, blue=6'd40 -> exact=0; with macro video=4'h6 then 4'hE; without macro 4'h0 both.
REQ-026 SHALL test: hsync rise then 640 valid pixels -> col runs 0..639; 3 hsync rises -> row=3; vsync rise -> row=0, one-cycle frame_pulse.
REQ-027 SHALL test: 70000 mismatching pixels in one frame -> err_count=16'hFFFF at vsync, the next clean frame reports 0.
REQ-028 SHALL test: reset_n=0 for one cycle mid-line with in_valid=1 -> next cycle all outputs 0; no stale pixel emerges 2 cycles later.
REQ-029 SHALL test: gaps in in_valid -> video held, col does not advance.
